gcd_stein: RTL and testbench
============================

Name: gcd_stein

Overview:
Parametrised binary (Stein) GCD engine. It is the next-generation replacement for the subtract/swap GCD core in the arithmetic-unit datapath. It adds a valid/ready handshake on both the input and output sides, configurable operand width, and zero-operand handling. Reduction uses shifts plus one subtract per cycle, so the worst case is bounded by operand width rather than by operand ratio.

Parameters:
WIDTH, 32, operand and result width in bits; legal values are 8 to 64.
KW, $clog2(WIDTH+1), width of the common-power-of-two counter k. It is derived and must not be overridden.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand pair is valid
in_ready  output  1  engine can accept an operand pair
a_in  input  WIDTH  operand a, unsigned
b_in  input  WIDTH  operand b, unsigned
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
result  output  WIDTH  gcd(a,b)
zero_err  output  1  both operands were zero; qualified by out_valid

Behaviour:
- Reset (async, active-low):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, result=0, zero_err=0.
  - Internal u, v and k are cleared.
- FSM states: IDLE, STRIP, REDUCE, FINISH, HOLD.
- IDLE:
  - in_ready=1.
  - Input handshake is in_valid&&in_ready; on it, load u=a_in, v=b_in, k=0.
  - If a_in==0 or b_in==0, go to FINISH with u=a_in|b_in and zero_err set iff both are 0.
  - Otherwise go to STRIP.
- in_ready=0 in every state except IDLE. in_valid is ignored while busy, and no operands are dropped silently.
- STRIP: while u[0]==0 && v[0]==0, set u>>=1, v>>=1, k+=1 (one shift per cycle). Otherwise go to REDUCE.
- REDUCE, one step per cycle, priority in order:
  - u even: u>>=1.
  - else v even: v>>=1.
  - else u==v: go to FINISH.
  - else u>v: u=u-v.
  - else: v=v-u.
- REDUCE invariants: u and v are never 0, and the subtract never underflows.
- FINISH (1 cycle): result <= u<<k. Shift width is WIDTH and no bits are lost because k is bounded by the operand. Go to HOLD.
- HOLD:
  - out_valid=1; result and zero_err are stable.
  - When out_valid&&out_ready: out_valid<=0, go to IDLE, in_ready=1 on the next cycle.
  - Backpressure is indefinite; result must not change while out_valid=1.
- There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Latency from input handshake to out_valid: 2 cycles for a zero operand. Otherwise 1 + strip + reduce + 1 cycles, with a worst case of about 2*WIDTH+2.
- result holds its last value in IDLE. zero_err is cleared on the next input handshake.
- Reset mid-operation aborts immediately with no output, and returns to reset values.
- gcd(x,x)=x. gcd(1,x)=1.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- When defined:
  - Adds output port cycles, 16 bits, giving the number of clk cycles from the input handshake to out_valid rising.
  - The count saturates at 16'hFFFF and is stable while out_valid=1.
  - Reset value is 0.
- When undefined, the port and counter do not exist and all other behaviour is identical.

Test Plan:
- a=48, b=18, out_ready=1 -> result=6, zero_err=0, single out_valid pulse, in_ready returns to 1 the next cycle.
- a=0, b=0 -> result=0, zero_err=1, out_valid exactly 2 cycles after the handshake. Also a=0, b=35 -> result=35, zero_err=0.
- WIDTH=32, a=32'h8000_0000, b=32'h4000_0000 -> result=32'h4000_0000 (k=30, strip path); a=32'hFFFF_FFFF, b=1 -> result=1.
- Hold out_ready=0 for 20 cycles after a=270, b=192 -> out_valid stays 1 with result=6 stable, in_ready=0 throughout; on out_ready=1, one transfer.
- Pulse in_valid with a=9, b=6 while busy on a=100, b=75 -> second pair not accepted; result=25, then in_ready=1, new handshake -> result=3.
- Assert reset_n=0 during REDUCE for a=1071, b=462 -> out_valid=0 and in_ready=1 at once; after release, a=1071, b=462 -> result=21 (with GCD_CYCLE_COUNT_EN, cycles>0 and matches the model).

Source files
------------

// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD engine with valid/ready handshakes on both sides.
// Operands are unsigned WIDTH-bit values. A zero operand bypasses the reduction,
// and both-zero raises zero_err alongside the result.
// Optional build macro GCD_CYCLE_COUNT_EN adds a 16-bit 'cycles' output: the
// number of clk cycles from the input handshake to out_valid rising (saturating).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready=1, waiting for an operand pair
// STRIP  | shifting out common factors of two, counting them in k
// REDUCE | one shift or one subtract per cycle until u==v
// FINISH | result <= u << k, raise out_valid
// HOLD   | out_valid=1, result stable until out_ready

module gcd_stein #(
  parameter int WIDTH = 32,
  localparam int KW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_err
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycles
`endif
);

  generate
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("gcd_stein: WIDTH must be in 8..64");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STRIP  = 3'd1,
    REDUCE = 3'd2,
    FINISH = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [KW-1:0]    k;

  logic handshake;
  assign handshake = in_valid && in_ready;

  // Control FSM and datapath: operand load, strip, reduce, final shift, output hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero_err  <= 1'b0;
      u         <= '0;
      v         <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            in_ready <= 1'b0;
            k        <= '0;
            v        <= b_in;
            if (a_in == '0 || b_in == '0) begin
              // a|b is the nonzero operand, or zero when both are zero.
              u        <= a_in | b_in;
              zero_err <= (a_in == '0) && (b_in == '0);
              state    <= FINISH;
            end else begin
              u        <= a_in;
              zero_err <= 1'b0;
              state    <= STRIP;
            end
          end
        end
        STRIP: begin
          if (!u[0] && !v[0]) begin
            u <= u >> 1;
            v <= v >> 1;
            k <= k + 1'b1;
          end else begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          // At least one of u, v is odd here, so the subtract of the smaller from
          // the larger never underflows and never produces zero.
          if (!u[0]) begin
            u <= u >> 1;
          end else if (!v[0]) begin
            v <= v >> 1;
          end else if (u == v) begin
            state <= FINISH;
          end else if (u > v) begin
            u <= u - v;
          end else begin
            v <= v - u;
          end
        end
        FINISH: begin
          // k only counts factors shared by both nonzero operands, so u<<k fits.
          result    <= u << k;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  // Latency counter: starts at 1 on the handshake edge, counts every busy edge, freezes in HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycles <= '0;
    end else if (state == IDLE) begin
      if (handshake) begin
        cycles <= 16'd1;
      end
    end else if (state == STRIP || state == REDUCE || state == FINISH) begin
      if (cycles != 16'hFFFF) begin
        cycles <= cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein (WIDTH=32): directed cases with literal
// expectations plus randomized operand pairs against a Euclid-based reference.
module tb_gcd_stein;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero_err;
`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0]  cycles;
`endif

  gcd_stein #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_err  (zero_err)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles    (cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zerr;
    int           lat;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference gcd by Euclid's remainder method (independent of the binary algorithm).
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Cycles from the handshake edge to the edge raising out_valid, from the
  // algorithm's step rules: handshake, strip shifts + exit, reduce steps + equal, finish.
  function automatic int lat_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    int n;
    if (a == 0 || b == 0) return 2;
    x = a;
    y = b;
    n = 1;
    while (x % 2 == 0 && y % 2 == 0) begin
      x = x / 2;
      y = y / 2;
      n++;
    end
    n++;
    while (x != y) begin
      if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y) x = x - y;
      else y = y - x;
      n++;
    end
    return n + 2;
  endfunction

  // Output monitor: scoreboard compare of every meaningful output cycle.
  int   lat_cnt = 0;
  bit   pending = 0;
  bit   ready_next = 0;
  logic [15:0] held_cycles = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      q.delete();
      pending    = 0;
      ready_next = 0;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    end else begin
      if (pending) begin
        lat_cnt++;
        if (!out_valid) check("busy_in_ready", {63'd0, in_ready}, 64'd0);
      end
      if (ready_next) begin
        check("post_xfer_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_xfer_out_valid", {63'd0, out_valid}, 64'd0);
        ready_next = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = q[0];
          if (pending) begin
            check("latency", 64'(lat_cnt), 64'(e.lat));
`ifdef GCD_CYCLE_COUNT_EN
            check("cycles", {48'd0, cycles}, 64'(e.lat));
            held_cycles = cycles;
`endif
            pending = 0;
          end
          check("result", {32'd0, result}, {32'd0, e.res});
          check("zero_err", {63'd0, zero_err}, {63'd0, e.zerr});
          check("hold_in_ready", {63'd0, in_ready}, 64'd0);
`ifdef GCD_CYCLE_COUNT_EN
          check("cycles_stable", {48'd0, cycles}, {48'd0, held_cycles});
`endif
          if (out_ready) begin
            void'(q.pop_front());
            ready_next = 1;
          end
        end
      end else if (pending && lat_cnt > 400) begin
        check("out_valid_timeout", 64'd0, 64'd1);
        pending = 0;
        q.delete();
      end
      if (in_valid && in_ready) begin
        e.res  = gcd_ref(a_in, b_in);
        e.zerr = (a_in == 0) && (b_in == 0);
        e.lat  = lat_ref(a_in, b_in);
        q.push_back(e);
        pending = 1;
        lat_cnt = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold, output logic [W-1:0] r, output logic z);
    int n = 0;
    r = '0;
    z = 1'b0;
    while (!out_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("collect_timeout", 64'd0, 64'd1);
      return;
    end
    r = result;
    z = zero_err;
    if (!out_ready) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input logic [W-1:0] er, input logic ez);
    logic [W-1:0] r;
    logic z;
    send(a, b);
    collect(hold, r, z);
    check({name, "_res"}, {32'd0, r}, {32'd0, er});
    check({name, "_zerr"}, {63'd0, z}, {63'd0, ez});
  endtask

  initial begin
    logic [W-1:0] r, a, b;
    logic z;
    int mode, sh;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_zero_err", {63'd0, zero_err}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef GCD_CYCLE_COUNT_EN
    check("reset_cycles", {48'd0, cycles}, 64'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    run_lit("g48_18", 32'd48, 32'd18, 0, 32'd6, 1'b0);
    out_ready = 1'b1;
    run_lit("zero_zero", 32'd0, 32'd0, 0, 32'd0, 1'b1);
    run_lit("zero_35", 32'd0, 32'd35, 2, 32'd35, 1'b0);
    run_lit("pow2", 32'h8000_0000, 32'h4000_0000, 1, 32'h4000_0000, 1'b0);
    run_lit("max_1", 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 1'b0);
    run_lit("hold20", 32'd270, 32'd192, 20, 32'd6, 1'b0);
    run_lit("same", 32'd12345, 32'd12345, 0, 32'd12345, 1'b0);

    // Busy pulse must be ignored.
    send(32'd100, 32'd75);
    in_valid = 1'b1;
    a_in = 32'd9;
    b_in = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(0, r, z);
    check("busy_first_res", {32'd0, r}, 64'd25);
    run_lit("after_busy", 32'd9, 32'd6, 0, 32'd3, 1'b0);

    // Reset during reduction aborts with no output.
    send(32'd1071, 32'd462);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_lit("after_abort", 32'd1071, 32'd462, 0, 32'd21, 1'b0);

    // Randomized pairs against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 4);
      case (mode)
        1: begin
          sh = $urandom_range(0, 24);
          a = (a >> sh) << sh;
          b = (b >> sh) << sh;
          a[sh] = 1'b1;
        end
        2: b = a;
        3: a = 32'd1;
        4: begin
          a = $urandom_range(0, 50);
          b = $urandom_range(0, 50);
        end
        default: ;
      endcase
      out_ready = ($urandom_range(0, 1) == 1);
      send(a, b);
      collect($urandom_range(0, 3), r, z);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
